ascon_absorb_engine: RTL and testbench

//  Streaming absorb stage for all four Ascon modes (AEAD128 AD/message, Hash256, XOF128, CXOF128).

---
 rtl/ascon_absorb_engine_pkg.sv | 56 +++++
 rtl/ascon_absorb_engine_if.sv | 26 ++
 rtl/ascon_absorb_engine_round.sv | 41 ++++
 rtl/ascon_absorb_engine.sv | 149 ++++++++++++++
 tb/tb_ascon_absorb_engine.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ascon_absorb_engine_pkg.sv
// Shared types, mode helpers and round-constant function for the Ascon absorb stage.
// State lanes are packed so that x0 occupies the top 64 bits of the 320-bit vector.
package ascon_absorb_engine_pkg;

    localparam int STATE_W  = 320;
    localparam int LANE_W   = 64;
    localparam int RATE_MAX = 16;
    localparam int LAST_RND = 12;

    localparam logic [63:0] DSEP = 64'h8000_0000_0000_0000;

    typedef enum logic [1:0] {
        MODE_AEAD = 2'b00,
        MODE_HASH = 2'b01,
        MODE_XOF  = 2'b10,
        MODE_CXOF = 2'b11
    } mode_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ABSORB,
        S_PERM,
        S_PAD,
        S_DONE
    } fsm_t;

    typedef struct packed {
        logic [LANE_W-1:0] x0;
        logic [LANE_W-1:0] x1;
        logic [LANE_W-1:0] x2;
        logic [LANE_W-1:0] x3;
        logic [LANE_W-1:0] x4;
    } state_t;

    function automatic logic [4:0] rate_bytes(mode_t m);
        return (m == MODE_AEAD) ? 5'd16 : 5'd8;
    endfunction

    function automatic logic [3:0] nr_rounds(mode_t m);
        return (m == MODE_AEAD) ? 4'd8 : 4'd12;
    endfunction

    // Every permutation ends on round 11, so the start index is 12 - NR.
    function automatic logic [3:0] first_round(mode_t m);
        return (m == MODE_AEAD) ? 4'd4 : 4'd0;
    endfunction

    function automatic logic [7:0] rc(logic [3:0] r);
        return {4'hF - r, r};
    endfunction

    function automatic logic [63:0] ror64(logic [63:0] v, int unsigned n);
        return (v >> n) | (v << (64 - n));
    endfunction

endpackage

// File: rtl/ascon_absorb_engine_if.sv
// Rate-block stream between the feeder and the absorb engine.
interface ascon_absorb_engine_if;

    logic         blk_valid;
    logic         blk_ready;
    logic [127:0] blk_data;
    logic [4:0]   blk_bytes;
    logic         blk_last;

    modport master (
        output blk_valid,
        output blk_data,
        output blk_bytes,
        output blk_last,
        input  blk_ready
    );

    modport slave (
        input  blk_valid,
        input  blk_data,
        input  blk_bytes,
        input  blk_last,
        output blk_ready
    );

endinterface

// File: rtl/ascon_absorb_engine_round.sv
// One combinational Ascon round: constant addition, bitsliced 5-bit s-box, linear diffusion.
module ascon_absorb_engine_round
    import ascon_absorb_engine_pkg::*;
(
    input  logic [3:0] rnd,
    input  state_t     s_in,
    output state_t     s_out
);

    logic [63:0] a0, a1, a2, a3, a4;
    logic [63:0] b0, b1, b2, b3, b4;
    logic [63:0] c0, c1, c2, c3, c4;

    always_comb begin
        // Round constant folded into the first s-box XOR on x2.
        a0 = s_in.x0 ^ s_in.x4;
        a1 = s_in.x1;
        a2 = s_in.x2 ^ {56'h0, rc(rnd)} ^ s_in.x1;
        a3 = s_in.x3;
        a4 = s_in.x4 ^ s_in.x3;

        b0 = a0 ^ (~a1 & a2);
        b1 = a1 ^ (~a2 & a3);
        b2 = a2 ^ (~a3 & a4);
        b3 = a3 ^ (~a4 & a0);
        b4 = a4 ^ (~a0 & a1);

        c0 = b0 ^ b4;
        c1 = b1 ^ b0;
        c2 = ~b2;
        c3 = b3 ^ b2;
        c4 = b4;

        s_out.x0 = c0 ^ ror64(c0, 19) ^ ror64(c0, 28);
        s_out.x1 = c1 ^ ror64(c1, 61) ^ ror64(c1, 39);
        s_out.x2 = c2 ^ ror64(c2, 1)  ^ ror64(c2, 6);
        s_out.x3 = c3 ^ ror64(c3, 10) ^ ror64(c3, 17);
        s_out.x4 = c4 ^ ror64(c4, 7)  ^ ror64(c4, 41);
    end

endmodule

// File: rtl/ascon_absorb_engine.sv
// Streaming Ascon absorb stage: XORs padded rate blocks into the state and runs the
// permutation UNROLL rounds per clock (UNROLL must be 1, 2 or 4).
module ascon_absorb_engine
    import ascon_absorb_engine_pkg::*;
#(
    parameter int UNROLL = 1
)
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   init_valid,
    input  logic [1:0]             mode_i,
    input  logic [STATE_W-1:0]     state_i,
    ascon_absorb_engine_if.slave   blk,
    output logic                   busy,
    output logic                   done,
    output logic [STATE_W-1:0]     state_o,
    output logic                   err
);

    fsm_t       fsm_q, fsm_d;
    state_t     st_q, st_d;
    mode_t      mode_q, mode_d;
    logic [3:0] rnd_q, rnd_d;
    logic       last_q, last_d;
    logic       pad_q, pad_d;
    logic       err_q, err_d;

    logic [4:0]   rate;
    logic         bad_blk;
    logic         perm_last;
    logic [127:0] mix;

    state_t [UNROLL:0] chain;

    assign chain[0] = st_q;

    for (genvar i = 0; i < UNROLL; i++) begin : g_rnd
        ascon_absorb_engine_round u_round (
            .rnd   (rnd_q + 4'(i)),
            .s_in  (chain[i]),
            .s_out (chain[i+1])
        );
    end

    assign rate      = rate_bytes(mode_q);
    assign bad_blk   = (blk.blk_bytes > rate) || (!blk.blk_last && blk.blk_bytes != rate);
    assign perm_last = (rnd_q == 4'(LAST_RND - UNROLL));

    // Data bytes below blk_bytes plus the 10* pad byte when the block is short.
    always_comb begin
        mix = '0;
        for (int k = 0; k < RATE_MAX; k++) begin
            if (5'(k) < blk.blk_bytes)
                mix[8*k +: 8] = blk.blk_data[8*k +: 8];
            else if (5'(k) == blk.blk_bytes && blk.blk_bytes < rate)
                mix[8*k +: 8] = 8'h01;
        end
    end

    always_comb begin
        fsm_d  = fsm_q;
        st_d   = st_q;
        mode_d = mode_q;
        rnd_d  = rnd_q;
        last_d = last_q;
        pad_d  = pad_q;
        err_d  = err_q;
        unique case (fsm_q)
            S_IDLE: begin
                if (init_valid) begin
                    st_d   = state_t'(state_i);
                    mode_d = mode_t'(mode_i);
                    err_d  = 1'b0;
                    fsm_d  = S_ABSORB;
                end
            end
            S_ABSORB: begin
                if (blk.blk_valid) begin
                    if (bad_blk) begin
                        err_d = 1'b1;
                    end else begin
                        st_d.x0 = st_q.x0 ^ mix[63:0];
                        st_d.x1 = st_q.x1 ^ mix[127:64];
                        rnd_d   = first_round(mode_q);
                        last_d  = blk.blk_last;
                        pad_d   = blk.blk_last && (blk.blk_bytes == rate);
                        fsm_d   = S_PERM;
                    end
                end
            end
            S_PERM: begin
                st_d  = chain[UNROLL];
                rnd_d = rnd_q + 4'(UNROLL);
                if (perm_last) begin
                    if (pad_q) begin
                        fsm_d = S_PAD;
                    end else if (last_q) begin
                        if (mode_q == MODE_AEAD)
                            st_d.x4 = chain[UNROLL].x4 ^ DSEP;
                        fsm_d = S_DONE;
                    end else begin
                        fsm_d = S_ABSORB;
                    end
                end
            end
            S_PAD: begin
                // Full-rate final block: the pad lands alone in the next rate block.
                st_d.x0[7:0] = st_q.x0[7:0] ^ 8'h01;
                pad_d        = 1'b0;
                rnd_d        = first_round(mode_q);
                fsm_d        = S_PERM;
            end
            S_DONE: begin
                fsm_d = S_IDLE;
            end
            default: begin
                fsm_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q  <= S_IDLE;
            st_q   <= '0;
            mode_q <= MODE_AEAD;
            rnd_q  <= '0;
            last_q <= 1'b0;
            pad_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            fsm_q  <= fsm_d;
            st_q   <= st_d;
            mode_q <= mode_d;
            rnd_q  <= rnd_d;
            last_q <= last_d;
            pad_q  <= pad_d;
            err_q  <= err_d;
        end
    end

    assign blk.blk_ready = (fsm_q == S_ABSORB);
    assign busy          = (fsm_q != S_IDLE);
    assign done          = (fsm_q == S_DONE);
    assign state_o       = st_q;
    assign err           = err_q;

endmodule

// File: tb/tb_ascon_absorb_engine.sv
// Drives three engines (UNROLL = 1, 2, 4) with identical streams and checks them
// against a table-driven Ascon model.
module tb_ascon_absorb_engine;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         init_valid;
    logic [1:0]   mode_i;
    logic [319:0] state_i;
    logic         blk_valid;
    logic [127:0] blk_data;
    logic [4:0]   blk_bytes;
    logic         blk_last;

    logic [2:0]         rdy, dn, bsy, er;
    logic [2:0][319:0]  so;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        ascon_absorb_engine_if bus ();
        assign bus.blk_valid = blk_valid;
        assign bus.blk_data  = blk_data;
        assign bus.blk_bytes = blk_bytes;
        assign bus.blk_last  = blk_last;
        assign rdy[g]        = bus.blk_ready;

        ascon_absorb_engine #(.UNROLL(1 << g)) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .init_valid (init_valid),
            .mode_i     (mode_i),
            .state_i    (state_i),
            .blk        (bus),
            .busy       (bsy[g]),
            .done       (dn[g]),
            .state_o    (so[g]),
            .err        (er[g])
        );
    end

    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };
    localparam int UN [3] = '{1, 2, 4};

    int total = 0;
    int bad   = 0;

    logic [63:0]  mx [5];
    bit           m_err;
    int           m_mode;

    int           done_cnt [3] = '{0, 0, 0};
    logic [319:0] done_st  [3];

    task automatic chk(input string tag, input logic [319:0] got, input logic [319:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++)
            if (dn[i] === 1'b1) begin
                done_cnt[i] = done_cnt[i] + 1;
                done_st[i]  = so[i];
            end
    end

    // ---------------- reference model ----------------
    function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    function automatic logic [319:0] mstate();
        return {mx[0], mx[1], mx[2], mx[3], mx[4]};
    endfunction

    task automatic m_perm(input int nr);
        logic [4:0] idx, o;
        for (int r = 12 - nr; r < 12; r++) begin
            mx[2] ^= 64'((15 - r) * 16 + r);
            for (int b = 0; b < 64; b++) begin
                idx = {mx[0][b], mx[1][b], mx[2][b], mx[3][b], mx[4][b]};
                o   = SBOX[idx];
                {mx[0][b], mx[1][b], mx[2][b], mx[3][b], mx[4][b]} = o;
            end
            mx[0] = mx[0] ^ rotr(mx[0], 19) ^ rotr(mx[0], 28);
            mx[1] = mx[1] ^ rotr(mx[1], 61) ^ rotr(mx[1], 39);
            mx[2] = mx[2] ^ rotr(mx[2], 1)  ^ rotr(mx[2], 6);
            mx[3] = mx[3] ^ rotr(mx[3], 10) ^ rotr(mx[3], 17);
            mx[4] = mx[4] ^ rotr(mx[4], 7)  ^ rotr(mx[4], 41);
        end
    endtask

    function automatic int m_rate();
        return (m_mode == 0) ? 16 : 8;
    endfunction

    function automatic int m_nr();
        return (m_mode == 0) ? 8 : 12;
    endfunction

    function automatic bit m_bad(input int nb, input bit last);
        return (nb > m_rate()) || (!last && nb != m_rate());
    endfunction

    task automatic m_block(input logic [127:0] d, input int nb, input bit last);
        if (m_bad(nb, last)) begin
            m_err = 1'b1;
        end else begin
            for (int k = 0; k < nb; k++)
                mx[k / 8] ^= 64'(d[8*k +: 8]) << (8 * (k % 8));
            if (nb < m_rate())
                mx[nb / 8] ^= 64'h01 << (8 * (nb % 8));
            m_perm(m_nr());
            if (last) begin
                if (nb == m_rate()) begin
                    mx[0] ^= 64'h01;
                    m_perm(m_nr());
                end
                if (m_mode == 0)
                    mx[4] ^= 64'h8000_0000_0000_0000;
            end
        end
    endtask

    // ---------------- drivers ----------------
    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [319:0] rnd320();
        return {rnd128(), rnd128(), $urandom, $urandom};
    endfunction

    task automatic do_init(input int mode, input logic [319:0] st);
        init_valid = 1'b1;
        mode_i     = mode[1:0];
        state_i    = st;
        @(negedge clk);
        init_valid = 1'b0;
        state_i    = rnd320();
        {mx[0], mx[1], mx[2], mx[3], mx[4]} = st;
        m_err  = 1'b0;
        m_mode = mode;
        for (int i = 0; i < 3; i++) begin
            chk("init_busy", bsy[i], 1);
            chk("init_err", er[i], 0);
            chk("init_state", so[i], st);
        end
    endtask

    task automatic hs(input logic [127:0] d, input int nb, input bit last);
        int w = 0;
        while (rdy !== 3'b111 && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (w >= 200) chk("ready_timeout", rdy, 3'b111);
        blk_valid = 1'b1;
        blk_data  = d;
        blk_bytes = 5'(nb);
        blk_last  = last;
        @(negedge clk);
        blk_valid = 1'b0;
        blk_data  = rnd128();
    endtask

    task automatic wait_done(input int base0, input int base1, input int base2);
        int w = 0;
        int base [3];
        base = '{base0, base1, base2};
        while (!(done_cnt[0] > base[0] && done_cnt[1] > base[1] && done_cnt[2] > base[2]) && w < 400) begin
            @(negedge clk);
            w++;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("done_pulses", done_cnt[i] - base[i], 1);
            chk("done_state", done_st[i], mstate());
            chk("idle_after_done", bsy[i], 0);
            chk("err_after_done", er[i], m_err);
        end
    endtask

    task automatic send_blk(input logic [127:0] d, input int nb, input bit last);
        int  cnt [3];
        bit  hi  [3];
        bit  badb;
        int  b0, b1, b2;
        badb = m_bad(nb, last);
        b0 = done_cnt[0]; b1 = done_cnt[1]; b2 = done_cnt[2];
        hs(d, nb, last);
        m_block(d, nb, last);
        if (badb || !last) begin
            cnt = '{0, 0, 0};
            hi  = '{0, 0, 0};
            for (int c = 0; c < 40; c++) begin
                for (int i = 0; i < 3; i++)
                    if (!hi[i]) begin
                        if (rdy[i]) hi[i] = 1'b1;
                        else        cnt[i]++;
                    end
                if (hi[0] && hi[1] && hi[2]) break;
                @(negedge clk);
            end
            for (int i = 0; i < 3; i++) begin
                chk("ready_gap", cnt[i], badb ? 0 : m_nr() / UN[i]);
                chk("blk_state", so[i], mstate());
                chk("blk_err", er[i], m_err);
            end
        end else begin
            wait_done(b0, b1, b2);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [127:0] d;
        int           mode, nfull, nb;

        rst_n      = 1'b0;
        init_valid = 1'b0;
        mode_i     = 2'b00;
        state_i    = '0;
        blk_valid  = 1'b0;
        blk_data   = '0;
        blk_bytes  = '0;
        blk_last   = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("rst_state", so[i], 0);
            chk("rst_flags", {rdy[i], bsy[i], dn[i], er[i]}, 0);
        end
        rst_n = 1'b1;

        // Block offered while idle must be ignored.
        blk_valid = 1'b1; blk_data = rnd128(); blk_bytes = 5'd8; blk_last = 1'b1;
        @(negedge clk);
        blk_valid = 1'b0;
        for (int i = 0; i < 3; i++)
            chk("idle_blk_ignored", {so[i], bsy[i], er[i]}, 0);

        // AEAD: 16 + 16 + 5 bytes with byte values 0x00..0x24.
        do_init(0, rnd320());
        for (int k = 0; k < 16; k++) d[8*k +: 8] = 8'(k);
        send_blk(d, 16, 0);
        for (int k = 0; k < 16; k++) d[8*k +: 8] = 8'(16 + k);
        send_blk(d, 16, 0);
        d = rnd128();
        for (int k = 0; k < 5; k++) d[8*k +: 8] = 8'(32 + k);
        send_blk(d, 5, 1);

        // Hash256 single full block: extra pad pass; init pulse during PERM is ignored.
        do_init(1, rnd320());
        begin
            int b0, b1, b2;
            b0 = done_cnt[0]; b1 = done_cnt[1]; b2 = done_cnt[2];
            d = rnd128();
            hs(d, 8, 1);
            m_block(d, 8, 1);
            init_valid = 1'b1; mode_i = 2'b10; state_i = rnd320();
            @(negedge clk);
            init_valid = 1'b0;
            wait_done(b0, b1, b2);
        end

        // AEAD empty last block on an all-zero state.
        do_init(0, '0);
        send_blk(rnd128(), 0, 1);

        // Protocol errors: oversize, oversize-last, short non-last; err is sticky.
        do_init(1, rnd320());
        send_blk(rnd128(), 9, 0);
        send_blk(rnd128(), 9, 1);
        send_blk(rnd128(), 5, 0);
        send_blk(rnd128(), 8, 0);
        send_blk(rnd128(), 3, 1);
        do_init(2, rnd320());
        send_blk(rnd128(), 8, 1);

        // Random operations across all modes.
        for (int it = 0; it < 12; it++) begin
            mode  = int'($urandom_range(0, 3));
            nfull = int'($urandom_range(0, 2));
            do_init(mode, rnd320());
            for (int b = 0; b < nfull; b++) begin
                if ($urandom_range(0, 3) == 0)
                    send_blk(rnd128(), int'($urandom_range(0, m_rate() - 1)), 0);
                send_blk(rnd128(), m_rate(), 0);
            end
            nb = int'($urandom_range(0, m_rate()));
            send_blk(rnd128(), nb, 1);
        end

        // Asynchronous reset during the third PERM cycle.
        do_init(0, rnd320());
        hs(rnd128(), 16, 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("abort_state", so[i], 0);
            chk("abort_flags", {rdy[i], bsy[i], er[i]}, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_init(3, rnd320());
        send_blk(rnd128(), 8, 0);
        send_blk(rnd128(), 2, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
